fp_to_int_seq: RTL and testbench
================================

FP_TO_INT_SEQ -- requirements
Module: fp_to_int_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand present.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts an operand; high only in IDLE and low while rst is high.
REQ-005 SHALL have port fp_in, input, 32 bits: IEEE-754 binary32 operand.
REQ-006 SHALL have port r_mode, input, 3 bits: rounding mode (000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE).
REQ-007 SHALL have port out_valid, output, 1 bit: result present.
REQ-008 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-009 SHALL have port int_out, output, 32 bits: signed two's-complement result.
REQ-010 SHALL have port invalid, output, 1 bit: NaN, infinity or out-of-range operand.
REQ-011 SHALL have port inexact, output, 1 bit: a nonzero fraction was discarded.

Function
REQ-012 SHALL accept an operand when in_valid && in_ready, in accept cycle 0, capturing fp_in and r_mode.
REQ-013 SHALL use FSM states IDLE -> SHIFT -> ROUND -> DONE -> IDLE; special operands go IDLE -> ROUND directly.
REQ-014 SHALL unpack operands as follows:
- exp field 0: hidden bit 0, e = -126.
- otherwise: hidden bit 1, e = exp - 127.
- the working magnitude is the 24-bit mantissa.
REQ-015 SHALL treat as special: NaN, infinity, and any finite operand with e >= 31.
REQ-016 SHALL, for e >= 23, left-shift the magnitude by e-23 in one SHIFT cycle, with guard = sticky = 0.
REQ-017 SHALL, for e < 23 without the fast-shift feature, right-shift one bit per SHIFT cycle for S = min(23-e, 25) cycles, updating guard and OR-ing into sticky.
REQ-018 SHALL increment the magnitude in ROUND when:
- RNE: g && (s || lsb).
- RTZ: never.
- RDN: sign && (g || s).
- RUP: !sign && (g || s).
- RMM: g.
After rounding, the result SHALL be negated if sign = 1.
REQ-019 SHALL produce these special results:
- NaN and +inf: 0x7FFFFFFF with invalid = 1.
- -inf: 0x80000000 with invalid = 1.
- positive with e >= 31: 0x7FFFFFFF with invalid = 1.
- negative with e >= 31: 0x80000000 with invalid = 1, except fp_in = 0xCF000000, which gives 0x80000000 with invalid = 0.
REQ-020 SHALL set inexact = (g || s) && !invalid; invalid and inexact are never both 1.
REQ-021 SHALL raise out_valid in cycle S+2 (special operands: cycle 2), with int_out, invalid and inexact registered in the same cycle.
REQ-022 SHALL hold int_out, invalid and inexact stable while out_valid && !out_ready.
REQ-023 SHALL return to IDLE on out_valid && out_ready, giving a minimum one-cycle bubble between results.
REQ-024 SHALL ignore in_valid outside IDLE; fp_in changes during processing have no effect.

Reset
REQ-025 SHALL, while rst is high, force state IDLE, out_valid = 0, int_out = 0x00000000, invalid = 0 and inexact = 0.
REQ-026 SHALL, on rst asserted mid-operation (SHIFT, ROUND or DONE), discard the operand; no result is ever emitted for it.

Configuration
REQ-027 SHALL, with FP2INT_FAST_SHIFT_EN defined, perform any right shift as one barrel shift with sticky reduction in a single SHIFT cycle (S = 1 for all non-special operands).
REQ-028 SHALL, with FP2INT_FAST_SHIFT_EN undefined, use the iterative shifter of REQ-017.
REQ-029 SHALL produce bit-identical results, with or without FP2INT_FAST_SHIFT_EN, for identical operands and modes.

Structure
REQ-030 SHALL take from shared package fpu_pkg:
- rounding-mode enum rmode_e.
- binary32 field widths and bias constant 127.
- INT32 saturation constants 0x7FFFFFFF and 0x80000000.
- state enum fp2int_state_e.
REQ-031 SHALL place guard/sticky rounding decision and conditional negation in sub-module fp2int_round (combinational), instantiated once.

Verification
REQ-032 SHALL cover 1.5: fp_in 0x3FC00000 with RNE -> int_out 2, inexact 1; with RTZ -> 1, inexact 1.
REQ-033 SHALL cover 2.5 and -1.5:
- 0x40200000 with RNE -> 2; with RMM -> 3.
- 0xBFC00000 with RDN -> 0xFFFFFFFE; with RUP -> 0xFFFFFFFF.
REQ-034 SHALL cover range limits:
- 0x4F000000 -> 0x7FFFFFFF, invalid 1.
- 0xCF000000 -> 0x80000000, invalid 0.
- 0x7FC00000 -> 0x7FFFFFFF, invalid 1.
- 0xFF800000 -> 0x80000000, invalid 1.
REQ-035 SHALL cover subnormals: 0x00000001 with RUP -> 1, inexact 1; with RNE -> 0, inexact 1; 0x80000000 with RDN -> 0, inexact 0.
REQ-036 SHALL cover latency and back-pressure:
- 0x3F800000 -> out_valid in cycle 25 without FP2INT_FAST_SHIFT_EN, cycle 3 with it, int_out 1.
- out_ready held low 5 cycles -> outputs stable.
REQ-037 SHALL cover reset mid-operation: rst pulsed in SHIFT cycle 4 -> out_valid stays 0, in_ready high the cycle after rst deasserts, and the next operand converts correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared FPU definitions: binary32 field layout, INT32 saturation values,
// rounding-mode and float-to-int sequencer state encodings.
package fpu_pkg;

  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int BIAS  = 127;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  // Biased exponent at which e = 23 (integer-aligned mantissa) and e = 31.
  localparam logic [7:0] EXP_LSH0 = 8'(BIAS + MAN_W);
  localparam logic [7:0] EXP_SAT  = 8'(BIAS + 31);
  // Beyond 25 right shifts every mantissa bit is already in sticky.
  localparam logic [4:0] RSH_MAX  = 5'd25;

  typedef enum logic [2:0] {
    RM_RNE = 3'b000,
    RM_RTZ = 3'b001,
    RM_RDN = 3'b010,
    RM_RUP = 3'b011,
    RM_RMM = 3'b100
  } rmode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } fp2int_state_e;

endpackage

// File: rtl/fp2int_round.sv
// Rounding increment decision from guard/sticky and mode, then conditional
// two's-complement negation of the rounded magnitude. Purely combinational.
module fp2int_round
  import fpu_pkg::*;
(
  input  logic [31:0] mag,
  input  logic        guard,
  input  logic        sticky,
  input  logic        sign,
  input  logic [2:0]  rmode,
  output logic [31:0] result,
  output logic        inexact
);

  logic        inc;
  logic [31:0] rounded;

  // Increment decision per rounding mode; unused encodings behave as RNE.
  always_comb begin
    inc = 1'b0;
    case (rmode)
      RM_RTZ:  inc = 1'b0;
      RM_RDN:  inc = sign & (guard | sticky);
      RM_RUP:  inc = ~sign & (guard | sticky);
      RM_RMM:  inc = guard;
      default: inc = guard & (sticky | mag[0]);
    endcase
    rounded = mag + {31'd0, inc};
    result  = sign ? (~rounded + 32'd1) : rounded;
    inexact = guard | sticky;
  end

endmodule

// File: rtl/fp_to_int_seq.sv
// Sequential binary32 -> int32 converter with valid/ready handshakes.
// Optional macro FP2INT_FAST_SHIFT_EN: right shifts become one barrel shift
// with sticky reduction (one SHIFT cycle) instead of one bit per cycle.
//
// state    | meaning
// ST_IDLE  | waiting for an operand, in_ready high
// ST_SHIFT | aligning the mantissa to the integer point
// ST_ROUND | rounding/negation or special result, registering outputs
// ST_DONE  | result held until out_ready
module fp_to_int_seq
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  input  logic [2:0]  r_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        invalid,
  output logic        inexact
);

  fp2int_state_e state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d, sticky_q, sticky_d, sign_q, sign_d;
  logic        spec_q, spec_d, spec_inv_q, spec_inv_d, left_q, left_d;
  logic [2:0]  rmode_q, rmode_d;
  logic [4:0]  sh_q, sh_d;
`ifndef FP2INT_FAST_SHIFT_EN
  logic [4:0]  cnt_q, cnt_d;
`endif
  logic        out_valid_q, out_valid_d, invalid_q, invalid_d, inexact_q, inexact_d;
  logic [31:0] int_out_q, int_out_d;

  logic        in_sign, in_special, in_spec_inv;
  logic [7:0]  in_exp, in_rsh_raw;
  logic [23:0] in_man;
  logic [4:0]  in_rsh, in_lsh;
  logic [31:0] in_spec_res;
  logic [31:0] rnd_result;
  logic        rnd_inexact;

`ifdef FP2INT_FAST_SHIFT_EN
  logic [49:0] rsh_ext;
  assign rsh_ext = {mag_q[23:0], 26'd0} >> sh_q;
`endif

  // Operand classification and special-result selection at accept time.
  always_comb begin
    in_sign     = fp_in[31];
    in_exp      = fp_in[MAN_W +: EXP_W];
    in_man      = {(in_exp != 8'd0), fp_in[MAN_W-1:0]};
    in_special  = (in_exp >= EXP_SAT);
    in_rsh_raw  = (in_exp == 8'd0) ? (EXP_LSH0 - 8'd1) : (EXP_LSH0 - in_exp);
    in_rsh      = (in_rsh_raw > 8'(RSH_MAX)) ? RSH_MAX : in_rsh_raw[4:0];
    in_lsh      = in_exp[4:0] - EXP_LSH0[4:0];
    in_spec_inv = 1'b1;
    in_spec_res = in_sign ? INT32_MIN : INT32_MAX;
    if ((in_exp == 8'hFF) && (fp_in[MAN_W-1:0] != '0)) begin
      in_spec_res = INT32_MAX;
    end else if (fp_in == 32'hCF00_0000) begin
      in_spec_inv = 1'b0;
    end
  end

  fp2int_round u_round (
    .mag     (mag_q),
    .guard   (guard_q),
    .sticky  (sticky_q),
    .sign    (sign_q),
    .rmode   (rmode_q),
    .result  (rnd_result),
    .inexact (rnd_inexact)
  );

  // Next-state and datapath updates for the conversion sequence.
  always_comb begin
    state_d     = state_q;
    mag_d       = mag_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    sign_d      = sign_q;
    spec_d      = spec_q;
    spec_inv_d  = spec_inv_q;
    left_d      = left_q;
    rmode_d     = rmode_q;
    sh_d        = sh_q;
`ifndef FP2INT_FAST_SHIFT_EN
    cnt_d       = cnt_q;
`endif
    out_valid_d = out_valid_q;
    int_out_d   = int_out_q;
    invalid_d   = invalid_q;
    inexact_d   = inexact_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d     = in_sign;
          rmode_d    = r_mode;
          guard_d    = 1'b0;
          sticky_d   = 1'b0;
          spec_d     = in_special;
          spec_inv_d = in_spec_inv;
          left_d     = (in_exp >= EXP_LSH0);
          sh_d       = (in_exp >= EXP_LSH0) ? in_lsh : in_rsh;
`ifndef FP2INT_FAST_SHIFT_EN
          cnt_d      = in_rsh;
`endif
          if (in_special) begin
            mag_d   = in_spec_res;
            state_d = ST_ROUND;
          end else begin
            mag_d   = {8'd0, in_man};
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        if (left_q) begin
          mag_d   = mag_q << sh_q;
          state_d = ST_ROUND;
        end else begin
`ifdef FP2INT_FAST_SHIFT_EN
          mag_d    = {8'd0, rsh_ext[49:26]};
          guard_d  = rsh_ext[25];
          sticky_d = |rsh_ext[24:0];
          state_d  = ST_ROUND;
`else
          mag_d    = mag_q >> 1;
          guard_d  = mag_q[0];
          sticky_d = sticky_q | guard_q;
          cnt_d    = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = ST_ROUND;
`endif
        end
      end
      ST_ROUND: begin
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
        if (spec_q) begin
          int_out_d = mag_q;
          invalid_d = spec_inv_q;
          inexact_d = 1'b0;
        end else begin
          int_out_d = rnd_result;
          invalid_d = 1'b0;
          inexact_d = rnd_inexact;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops any operand in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mag_q       <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      sign_q      <= 1'b0;
      spec_q      <= 1'b0;
      spec_inv_q  <= 1'b0;
      left_q      <= 1'b0;
      rmode_q     <= '0;
      sh_q        <= '0;
`ifndef FP2INT_FAST_SHIFT_EN
      cnt_q       <= '0;
`endif
      out_valid_q <= 1'b0;
      int_out_q   <= '0;
      invalid_q   <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      sign_q      <= sign_d;
      spec_q      <= spec_d;
      spec_inv_q  <= spec_inv_d;
      left_q      <= left_d;
      rmode_q     <= rmode_d;
      sh_q        <= sh_d;
`ifndef FP2INT_FAST_SHIFT_EN
      cnt_q       <= cnt_d;
`endif
      out_valid_q <= out_valid_d;
      int_out_q   <= int_out_d;
      invalid_q   <= invalid_d;
      inexact_q   <= inexact_d;
    end
  end

  // Outputs read as idle/zero for the whole time rst is high.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = out_valid_q && !rst;
  assign int_out   = rst ? 32'd0 : int_out_q;
  assign invalid   = invalid_q && !rst;
  assign inexact   = inexact_q && !rst;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Bench for fp_to_int_seq: directed vector table, back-pressure, reset in
// mid-operation and randomized operands against an arithmetic reference.
module tb_fp_to_int_seq;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, invalid, inexact;
  logic [31:0] fp_in, int_out;
  logic [2:0]  r_mode;

  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fp_to_int_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fp_in     (fp_in),
    .r_mode    (r_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .int_out   (int_out),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  typedef struct {
    logic [31:0] fp;
    logic [2:0]  rm;
    logic [31:0] res;
    logic        inv;
    logic        inx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: exact value man * 2^(e-23), remainder compared against one half.
  function automatic void ref_model(input logic [31:0] fp, input logic [2:0] rm,
                                    output logic [31:0] res, output logic inv,
                                    output logic inx, output int lat);
    logic        sgn, up;
    int          ex, e, k;
    logic [63:0] man, mag, rem, half, sv;
    sgn = fp[31];
    ex  = int'(fp[30:23]);
    man = {40'd0, (ex != 0), fp[22:0]};
    inv = 1'b0; inx = 1'b0; res = 32'd0; up = 1'b0;
    if (ex == 255) begin
      inv = 1'b1; lat = 2;
      res = (fp[22:0] != 0 || !sgn) ? 32'h7FFFFFFF : 32'h80000000;
      return;
    end
    e = (ex == 0) ? -126 : ex - 127;
    if (e >= 31) begin
      lat = 2;
      res = sgn ? 32'h80000000 : 32'h7FFFFFFF;
      inv = (fp != 32'hCF000000);
      return;
    end
    if (e >= 23) begin
      mag = man << (e - 23); rem = 64'd0; half = 64'd1; lat = 3;
    end else begin
      k = 23 - e;
`ifdef FP2INT_FAST_SHIFT_EN
      lat = 3;
`else
      lat = ((k > 25) ? 25 : k) + 2;
`endif
      if (k > 40) k = 40;
      mag  = man >> k;
      half = 64'd1 << (k - 1);
      rem  = man & ((64'd1 << k) - 64'd1);
    end
    case (rm)
      3'd1:    up = 1'b0;
      3'd2:    up = sgn && (rem != 0);
      3'd3:    up = !sgn && (rem != 0);
      3'd4:    up = (rem >= half);
      default: up = (rem > half) || ((rem == half) && mag[0]);
    endcase
    mag = mag + 64'(up);
    sv  = sgn ? (~mag + 64'd1) : mag;
    res = sv[31:0];
    inx = (rem != 0);
  endfunction

  task automatic run_op(input logic [31:0] fp, input logic [2:0] rm, input int hold,
                        input logic [31:0] e_res, input logic e_inv, input logic e_inx);
    logic [31:0] m_res;
    logic        m_inv, m_inx;
    int          e_lat, lat;
    bit          seen;
    string       tag;
    ref_model(fp, rm, m_res, m_inv, m_inx, e_lat);
    tag = $sformatf("%h/rm%0d", fp, rm);
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin seen = 1; break; end
    end
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL in_ready_wait %s: in_ready never rose", tag);
      return;
    end
    in_valid = 1'b1; fp_in = fp; r_mode = rm;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_vec++;
    seen = 0; lat = 0;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (out_valid) begin lat = c; seen = 1; break; end
      in_valid = 1'($urandom); fp_in = $urandom; r_mode = 3'($urandom);
    end
    in_valid = 1'b0;
    if (!seen) begin
      n_cmp++; n_err++;
      $display("FAIL out_valid_wait %s: no result within 200 cycles", tag);
      return;
    end
    chk({tag, " latency"}, 32'(lat), 32'(e_lat));
    chk({tag, " int_out"}, int_out, e_res);
    chk({tag, " invalid"}, 32'(invalid), 32'(e_inv));
    chk({tag, " inexact"}, 32'(inexact), 32'(e_inx));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
      chk({tag, " hold int_out"}, int_out, e_res);
      chk({tag, " hold invalid"}, 32'(invalid), 32'(e_inv));
      chk({tag, " hold inexact"}, 32'(inexact), 32'(e_inx));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk({tag, " bubble out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] r_res, fp;
    logic        r_inv, r_inx;
    logic [2:0]  rm;
    int          r_lat, vcnt;

    vecs = '{
      '{32'h3FC00000, 3'd0, 32'h00000002, 1'b0, 1'b1},
      '{32'h3FC00000, 3'd1, 32'h00000001, 1'b0, 1'b1},
      '{32'h40200000, 3'd0, 32'h00000002, 1'b0, 1'b1},
      '{32'h40200000, 3'd4, 32'h00000003, 1'b0, 1'b1},
      '{32'h40200000, 3'd7, 32'h00000002, 1'b0, 1'b1},
      '{32'hBFC00000, 3'd2, 32'hFFFFFFFE, 1'b0, 1'b1},
      '{32'hBFC00000, 3'd3, 32'hFFFFFFFF, 1'b0, 1'b1},
      '{32'hC0200000, 3'd4, 32'hFFFFFFFD, 1'b0, 1'b1},
      '{32'h4F000000, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hCF000000, 3'd0, 32'h80000000, 1'b0, 1'b0},
      '{32'h7FC00000, 3'd0, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'hFF800000, 3'd0, 32'h80000000, 1'b1, 1'b0},
      '{32'h7F800000, 3'd1, 32'h7FFFFFFF, 1'b1, 1'b0},
      '{32'h4EFFFFFF, 3'd0, 32'h7FFFFF80, 1'b0, 1'b0},
      '{32'hCEFFFFFF, 3'd3, 32'h80000080, 1'b0, 1'b0},
      '{32'h4B000001, 3'd0, 32'h00800001, 1'b0, 1'b0},
      '{32'h00000001, 3'd3, 32'h00000001, 1'b0, 1'b1},
      '{32'h00000001, 3'd0, 32'h00000000, 1'b0, 1'b1},
      '{32'h80000000, 3'd2, 32'h00000000, 1'b0, 1'b0},
      '{32'h3F000000, 3'd0, 32'h00000000, 1'b0, 1'b1},
      '{32'h3F000000, 3'd4, 32'h00000001, 1'b0, 1'b1},
      '{32'h3F800000, 3'd0, 32'h00000001, 1'b0, 1'b0}
    };

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; fp_in = 32'd0; r_mode = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 32'(in_ready), 32'd0);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset int_out", int_out, 32'd0);
    chk("reset flags", {30'd0, invalid, inexact}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-reset in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i])
      run_op(vecs[i].fp, vecs[i].rm, 0, vecs[i].res, vecs[i].inv, vecs[i].inx);

    run_op(32'h3FC00000, 3'd0, 5, 32'h00000002, 1'b0, 1'b1);
    run_op(32'hFF800000, 3'd0, 5, 32'h80000000, 1'b1, 1'b0);

    // Reset while the operand is still being shifted.
    @(negedge clk);
    in_valid = 1'b1; fp_in = 32'h3F800000; r_mode = 3'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifndef FP2INT_FAST_SHIFT_EN
    repeat (3) @(posedge clk);
    #1;
`endif
    rst = 1'b1;
    @(negedge clk);
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst int_out", int_out, 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst in_ready after", 32'(in_ready), 32'd1);
    vcnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) vcnt++;
    end
    chk("midrst discarded", 32'(vcnt), 32'd0);
    run_op(32'h40200000, 3'd4, 0, 32'h00000003, 1'b0, 1'b1);

    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0:       fp = {1'($urandom), 8'd0, 23'($urandom)};
        1:       fp = {1'($urandom), 8'd255, 23'($urandom_range(0, 3))};
        2:       fp = {1'($urandom), 8'($urandom_range(150, 160)), 23'($urandom)};
        default: fp = {1'($urandom), 8'($urandom_range(100, 157)), 23'($urandom)};
      endcase
      rm = 3'($urandom_range(0, 7));
      ref_model(fp, rm, r_res, r_inv, r_inx, r_lat);
      run_op(fp, rm, int'($urandom_range(0, 2)), r_res, r_inv, r_inx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
